// File: rtl/csr_exec_pkg.sv
// Shared types for the CSR execute stage and the CSR register file.
package csr_exec_pkg;

  // CSR write command, also used by the csr register file's write port.
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_SET  = 2'b01,
    CSR_OR   = 2'b10,
    CSR_ANDN = 2'b11
  } csr_op_t;

  // Exception cause codes reported to writeback.
  typedef enum logic [3:0] {
    ECAUSE_NONE = 4'd0,
    IILLEGAL    = 4'd2
  } ecause_t;

  // Zicsr funct3 encodings.
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Execute-stage sequencing.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_RESP = 2'b10
  } exec_state_t;

endpackage

// File: rtl/csr_exec_decode.sv
// Combinational decode of a Zicsr instruction into a CSR port command.
module csr_exec_decode
  import csr_exec_pkg::*;
(
  input  logic [31:7] insn,
  input  logic [31:0] rs1_val,
  output logic [11:0] addr,
  output logic [4:0]  rd,
  output csr_op_t     op,
  output logic [31:0] wdata,
  output logic        illegal
);

  logic [2:0] f3;
  logic [4:0] src;
  csr_op_t    raw_op;

  assign rd   = insn[11:7];
  assign f3   = insn[14:12];
  assign src  = insn[19:15];
  assign addr = insn[31:20];

  // Immediate forms carry a zero-extended 5-bit value in the rs1 field.
  assign wdata = f3[2] ? {27'd0, src} : rs1_val;

  // Set/clear with a zero source never modifies the CSR, so it is a pure read.
  always_comb begin
    raw_op = CSR_NONE;
    case (f3)
      F3_CSRRW, F3_CSRRWI: raw_op = CSR_SET;
      F3_CSRRS, F3_CSRRSI: raw_op = (src == 5'd0) ? CSR_NONE : CSR_OR;
      F3_CSRRC, F3_CSRRCI: raw_op = (src == 5'd0) ? CSR_NONE : CSR_ANDN;
      default:             raw_op = CSR_NONE;
    endcase
  end

  // Unused funct3 encodings, or any write to the read-only CSR quadrant.
  assign illegal = (f3[1:0] == 2'b00) ||
                   ((addr[11:10] == 2'b11) && (raw_op != CSR_NONE));

  assign op = illegal ? CSR_NONE : raw_op;

endmodule

// File: rtl/csr_exec.sv
// CSR execute stage: one instruction in flight, single-cycle CSR access once
// all older instructions have retired, result held until writeback takes it.
module csr_exec
  import csr_exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [29:0] in_pc,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_rs1_val,
  input  logic        older_empty,
  input  logic        flush,
  output logic [11:0] csr_addr,
  output csr_op_t     csr_write,
  output logic [31:0] csr_wdata,
  input  logic        csr_error,
  input  logic [31:0] csr_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] out_pc,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_exc,
  output ecause_t     out_exc_cause
);

  exec_state_t state_reg, state_next;
  logic [29:0] pc_reg;
  logic [31:0] insn_reg;
  logic [31:0] opnd_reg;
  logic        fire;
  logic        fire_exc;
  logic [4:0]  dec_rd;
  csr_op_t     dec_op;
  logic        dec_illegal;

  logic [29:0] out_pc_reg;
  logic [4:0]  out_rd_reg;
  logic [31:0] out_data_reg;
  logic        out_exc_reg;
  ecause_t     out_cause_reg;

  csr_exec_decode u_decode (
    .insn    (insn_reg[31:7]),
    .rs1_val (opnd_reg),
    .addr    (csr_addr),
    .rd      (dec_rd),
    .op      (dec_op),
    .wdata   (csr_wdata),
    .illegal (dec_illegal)
  );

  assign fire_exc = dec_illegal | csr_error;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next state and handshake/CSR strobes; flush and reset override everything.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    csr_write  = CSR_NONE;
    fire       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_PEND;
      end
      ST_PEND: begin
        if (older_empty) begin
          fire       = 1'b1;
          csr_write  = dec_op;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush || reset) begin
      state_next = ST_IDLE;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      csr_write  = CSR_NONE;
      fire       = 1'b0;
    end
  end

  // Instruction capture on accept and result capture on the access cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg        <= '0;
      insn_reg      <= '0;
      opnd_reg      <= '0;
      out_pc_reg    <= '0;
      out_rd_reg    <= '0;
      out_data_reg  <= '0;
      out_exc_reg   <= 1'b0;
      out_cause_reg <= ECAUSE_NONE;
    end else begin
      if (in_valid && in_ready) begin
        pc_reg   <= in_pc;
        insn_reg <= in_insn;
        opnd_reg <= in_rs1_val;
      end
      if (fire) begin
        out_pc_reg    <= pc_reg;
        out_exc_reg   <= fire_exc;
        out_rd_reg    <= fire_exc ? 5'd0 : dec_rd;
        out_data_reg  <= fire_exc ? insn_reg : csr_rdata;
        out_cause_reg <= fire_exc ? IILLEGAL : ECAUSE_NONE;
      end
    end
  end

  assign out_pc        = out_pc_reg;
  assign out_rd        = out_rd_reg;
  assign out_data      = out_data_reg;
  assign out_exc       = out_exc_reg;
  assign out_exc_cause = out_cause_reg;

endmodule

// File: tb/tb_csr_exec.sv
// Directed testbench for csr_exec with a small CSR file model
// (mscratch 0x340, cycle 0xC00, instret 0xC02; other addresses error).
module tb_csr_exec;
  import csr_exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [29:0] in_pc = '0;
  logic [31:0] in_insn = '0;
  logic [31:0] in_rs1_val = '0;
  logic        older_empty = 1'b1;
  logic        flush = 1'b0;
  logic [11:0] csr_addr;
  csr_op_t     csr_write;
  logic [31:0] csr_wdata;
  logic        csr_error;
  logic [31:0] csr_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [29:0] out_pc;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_exc;
  ecause_t     out_exc_cause;

  int vectors = 0;
  int miscompares = 0;

  csr_exec dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
    .in_rs1_val(in_rs1_val), .older_empty(older_empty), .flush(flush),
    .csr_addr(csr_addr), .csr_write(csr_write), .csr_wdata(csr_wdata),
    .csr_error(csr_error), .csr_rdata(csr_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_data(out_data), .out_exc(out_exc), .out_exc_cause(out_exc_cause)
  );

  always #5 clk = ~clk;

  // CSR file model
  logic [31:0] mscratch = '0;
  logic [31:0] cyc = '0;
  int          wr_pulses = 0;

  always_comb begin
    csr_rdata = '0;
    csr_error = 1'b0;
    case (csr_addr)
      12'h340: csr_rdata = mscratch;
      12'hC00: csr_rdata = cyc;
      12'hC02: csr_rdata = 32'h0000_00AA;
      default: csr_error = 1'b1;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csr_write != CSR_NONE) wr_pulses <= wr_pulses + 1;
    if (reset) mscratch <= '0;
    else if (csr_write != CSR_NONE && !csr_error && csr_addr == 12'h340) begin
      case (csr_write)
        CSR_SET:  mscratch <= csr_wdata;
        CSR_OR:   mscratch <= mscratch | csr_wdata;
        CSR_ANDN: mscratch <= mscratch & ~csr_wdata;
        default:  mscratch <= mscratch;
      endcase
    end
  end

  function automatic logic [31:0] enc(input logic [11:0] a, input logic [4:0] s,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {a, s, f3, rd, 7'b1110011};
  endfunction

  // Observations captured by do_op
  logic        o_acc, o_valid, o_exc, o_pend_valid, o_idle_valid, o_idle_ready;
  csr_op_t     o_write, o_resp_write;
  logic [31:0] o_wdata, o_data, o_cyc;
  logic [11:0] o_addr;
  logic [4:0]  o_rd;
  logic [29:0] o_pc;
  ecause_t     o_cause;

  // Issue one instruction with older_empty=1 and immediate writeback acceptance.
  task automatic do_op(input logic [29:0] pc, input logic [31:0] insn, input logic [31:0] rs1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_pc = pc; in_insn = insn; in_rs1_val = rs1;
    older_empty = 1'b1; out_ready = 1'b0; #1;
    o_acc = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; #1;
    o_write = csr_write; o_wdata = csr_wdata; o_addr = csr_addr;
    o_cyc = cyc; o_pend_valid = out_valid;
    @(posedge clk); #1;
    out_ready = 1'b1; #1;
    o_valid = out_valid; o_data = out_data; o_rd = out_rd; o_pc = out_pc;
    o_exc = out_exc; o_cause = out_exc_cause; o_resp_write = csr_write;
    @(posedge clk); #1;
    out_ready = 1'b0; #1;
    o_idle_valid = out_valid; o_idle_ready = in_ready;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; in_insn = enc(12'h340, 5'd6, F3_CSRRW, 5'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (csr_write !== CSR_NONE) begin miscompares++; $display("FAIL reset_csr_write: got %b want 00", csr_write); end
    vectors++; if ({out_exc, out_data, out_rd, out_pc} !== '0) begin miscompares++;
      $display("FAIL reset_outs: exc=%b data=%h rd=%0d pc=%h want all 0", out_exc, out_data, out_rd, out_pc); end
    reset = 1'b0; in_valid = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    $display("reset: done");
  endtask

  task automatic test_csrrw;
    do_op(30'h0000_1000, enc(12'h340, 5'd6, F3_CSRRW, 5'd5), 32'h1234_5678);
    vectors++; if (o_acc !== 1'b1) begin miscompares++; $display("FAIL rw_accept: got %b want 1", o_acc); end
    vectors++; if (o_write !== CSR_SET) begin miscompares++; $display("FAIL rw_write: got %b want 01", o_write); end
    vectors++; if (o_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL rw_wdata: got %h want 12345678", o_wdata); end
    vectors++; if (o_addr !== 12'h340) begin miscompares++; $display("FAIL rw_addr: got %h want 340", o_addr); end
    vectors++; if (o_pend_valid !== 1'b0) begin miscompares++; $display("FAIL rw_early_valid: got %b want 0", o_pend_valid); end
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL rw_valid: got %b want 1", o_valid); end
    vectors++; if (o_rd !== 5'd5) begin miscompares++; $display("FAIL rw_rd: got %0d want 5", o_rd); end
    vectors++; if (o_data !== 32'h0) begin miscompares++; $display("FAIL rw_data: got %h want 0", o_data); end
    vectors++; if (o_exc !== 1'b0 || o_cause !== ECAUSE_NONE) begin miscompares++; $display("FAIL rw_exc: got %b/%0d want 0/0", o_exc, o_cause); end
    vectors++; if (o_pc !== 30'h0000_1000) begin miscompares++; $display("FAIL rw_pc: got %h want 1000", o_pc); end
    vectors++; if (o_resp_write !== CSR_NONE) begin miscompares++; $display("FAIL rw_resp_write: got %b want 00", o_resp_write); end
    vectors++; if (o_idle_valid !== 1'b0 || o_idle_ready !== 1'b1) begin miscompares++;
      $display("FAIL rw_idle: valid=%b ready=%b want 0/1", o_idle_valid, o_idle_ready); end
    $display("csrrw x5,0x340: data=%h rd=%0d", o_data, o_rd);

    do_op(30'h0000_1001, enc(12'h340, 5'd0, F3_CSRRS, 5'd8), 32'hFFFF_FFFF);
    vectors++; if (o_write !== CSR_NONE) begin miscompares++; $display("FAIL rs_x0_write: got %b want 00", o_write); end
    vectors++; if (o_data !== 32'h1234_5678) begin miscompares++; $display("FAIL readback: got %h want 12345678", o_data); end
    $display("csrrs x8,0x340,x0: data=%h", o_data);

    do_op(30'h0000_1002, enc(12'h340, 5'd10, F3_CSRRC, 5'd9), 32'h0000_FF00);
    vectors++; if (o_write !== CSR_ANDN || o_wdata !== 32'h0000_FF00) begin miscompares++;
      $display("FAIL rc_cmd: got %b/%h want 11/0000ff00", o_write, o_wdata); end
    vectors++; if (o_data !== 32'h1234_5678) begin miscompares++; $display("FAIL rc_data: got %h want 12345678", o_data); end
    $display("csrrc x9,0x340,x10: data=%h", o_data);

    do_op(30'h0000_1003, enc(12'h340, 5'h1F, F3_CSRRSI, 5'd11), 32'hFFFF_0000);
    vectors++; if (o_write !== CSR_OR || o_wdata !== 32'h0000_001F) begin miscompares++;
      $display("FAIL rsi_cmd: got %b/%h want 10/0000001f", o_write, o_wdata); end
    vectors++; if (o_data !== 32'h1234_0078) begin miscompares++; $display("FAIL rsi_data: got %h want 12340078", o_data); end
    $display("csrrsi x11,0x340,31: data=%h", o_data);
  endtask

  task automatic test_read_cycle;
    do_op(30'h0000_2000, enc(12'hC00, 5'd0, F3_CSRRS, 5'd7), 32'h5555_5555);
    vectors++; if (o_write !== CSR_NONE) begin miscompares++; $display("FAIL cycle_write: got %b want 00", o_write); end
    vectors++; if (o_data !== o_cyc) begin miscompares++; $display("FAIL cycle_data: got %h want %h", o_data, o_cyc); end
    vectors++; if (o_exc !== 1'b0 || o_rd !== 5'd7) begin miscompares++; $display("FAIL cycle_exc_rd: got %b/%0d want 0/7", o_exc, o_rd); end
    $display("csrrs x7,cycle,x0: data=%h", o_data);
  endtask

  task automatic test_illegal;
    logic [31:0] insn;
    insn = enc(12'hC02, 5'd5, F3_CSRRWI, 5'd1);
    do_op(30'h0000_3000, insn, 32'h0);
    vectors++; if (o_write !== CSR_NONE) begin miscompares++; $display("FAIL ro_write: got %b want 00", o_write); end
    vectors++; if (o_exc !== 1'b1 || o_cause !== IILLEGAL) begin miscompares++; $display("FAIL ro_exc: got %b/%0d want 1/2", o_exc, o_cause); end
    vectors++; if (o_data !== insn || o_rd !== 5'd0) begin miscompares++; $display("FAIL ro_data_rd: got %h/%0d want %h/0", o_data, o_rd, insn); end
    $display("csrrwi x1,0xC02,5: exc=%b data=%h", o_exc, o_data);

    insn = enc(12'hC00, 5'd3, F3_CSRRC, 5'd2);
    do_op(30'h0000_3001, insn, 32'h1);
    vectors++; if (o_exc !== 1'b1 || o_data !== insn || o_write !== CSR_NONE) begin miscompares++;
      $display("FAIL ro_clear: exc=%b data=%h write=%b want 1/%h/00", o_exc, o_data, o_write, insn); end
    $display("csrrc x2,cycle,x3: exc=%b", o_exc);

    insn = enc(12'h340, 5'd1, 3'b000, 5'd3);
    do_op(30'h0000_3002, insn, 32'h1);
    vectors++; if (o_exc !== 1'b1 || o_data !== insn || o_write !== CSR_NONE) begin miscompares++;
      $display("FAIL f3_000: exc=%b data=%h write=%b want 1/%h/00", o_exc, o_data, o_write, insn); end
    $display("f3=000: exc=%b", o_exc);

    insn = enc(12'h7C0, 5'd0, F3_CSRRS, 5'd4);
    do_op(30'h0000_3003, insn, 32'h0);
    vectors++; if (o_exc !== 1'b1 || o_cause !== IILLEGAL || o_data !== insn || o_rd !== 5'd0) begin miscompares++;
      $display("FAIL csr_error: exc=%b cause=%0d data=%h rd=%0d want 1/2/%h/0", o_exc, o_cause, o_data, o_rd, insn); end
    $display("csrrs x4,0x7C0 (csr error): exc=%b", o_exc);
  endtask

  task automatic test_older_wait;
    @(posedge clk); #1;
    in_valid = 1'b1; in_insn = enc(12'h340, 5'd16, F3_CSRRW, 5'd15); in_rs1_val = 32'hA5A5_A5A5;
    in_pc = 30'h0000_4000; older_empty = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (csr_write !== CSR_NONE || in_ready !== 1'b0 || out_valid !== 1'b0) begin miscompares++;
        $display("FAIL wait_%0d: write=%b ready=%b valid=%b want 00/0/0", k, csr_write, in_ready, out_valid); end
      @(posedge clk); #1;
    end
    older_empty = 1'b1; #1;
    vectors++; if (csr_write !== CSR_SET || csr_wdata !== 32'hA5A5_A5A5) begin miscompares++;
      $display("FAIL wait_fire: got %b/%h want 01/a5a5a5a5", csr_write, csr_wdata); end
    @(posedge clk); #1;
    out_ready = 1'b1; #1;
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h1234_007F || out_rd !== 5'd15) begin miscompares++;
      $display("FAIL wait_result: valid=%b data=%h rd=%0d want 1/1234007f/15", out_valid, out_data, out_rd); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("older wait: data=%h", out_data);
  endtask

  task automatic test_backpressure;
    int p0;
    p0 = wr_pulses;
    @(posedge clk); #1;
    in_valid = 1'b1; in_insn = enc(12'h340, 5'd13, F3_CSRRS, 5'd12); in_rs1_val = 32'h0F00_0000;
    in_pc = 30'h0000_5000; older_empty = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5 || out_rd !== 5'd12 ||
                     csr_write !== CSR_NONE || in_ready !== 1'b0) begin miscompares++;
        $display("FAIL stall_%0d: valid=%b data=%h rd=%0d write=%b ready=%b want 1/a5a5a5a5/12/00/0",
                 k, out_valid, out_data, out_rd, csr_write, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++; if (wr_pulses - p0 !== 1) begin miscompares++; $display("FAIL stall_pulses: got %0d want 1", wr_pulses - p0); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++;
      $display("FAIL stall_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    do_op(30'h0000_5001, enc(12'h340, 5'd0, F3_CSRRS, 5'd14), 32'h0);
    vectors++; if (o_acc !== 1'b1 || o_data !== 32'hAFA5_A5A5) begin miscompares++;
      $display("FAIL stall_next: acc=%b data=%h want 1/afa5a5a5", o_acc, o_data); end
    $display("backpressure: pulses=%0d next=%h", wr_pulses - p0, o_data);
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    in_valid = 1'b1; in_insn = enc(12'h340, 5'd18, F3_CSRRW, 5'd17); in_rs1_val = 32'hDEAD_BEEF;
    in_pc = 30'h0000_6000; older_empty = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1; #1;
    vectors++; if (csr_write !== CSR_NONE || in_ready !== 1'b0 || out_valid !== 1'b0) begin miscompares++;
      $display("FAIL flush_pend: write=%b ready=%b valid=%b want 00/0/0", csr_write, in_ready, out_valid); end
    @(posedge clk); #1;
    flush = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++;
      $display("FAIL flush_idle: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    do_op(30'h0000_6001, enc(12'h340, 5'd0, F3_CSRRS, 5'd19), 32'h0);
    vectors++; if (o_data !== 32'hAFA5_A5A5) begin miscompares++; $display("FAIL flush_mscratch: got %h want afa5a5a5", o_data); end
    $display("flush in PEND: mscratch=%h", o_data);

    // flush together with out_ready in RESP drops the result
    @(posedge clk); #1;
    in_valid = 1'b1; in_insn = enc(12'h340, 5'd0, F3_CSRRS, 5'd20); in_pc = 30'h0000_6002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_resp_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++;
      $display("FAIL flush_resp_idle: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    $display("flush in RESP: dropped");
  endtask

  task automatic test_reset_midop;
    @(posedge clk); #1;
    in_valid = 1'b1; in_insn = enc(12'h340, 5'd21, F3_CSRRW, 5'd20); in_rs1_val = 32'h1111_1111;
    in_pc = 30'h0000_7000; older_empty = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1; #1;
    vectors++; if (csr_write !== CSR_NONE) begin miscompares++; $display("FAIL rst_mid_write: got %b want 00", csr_write); end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_rd !== 5'd0 || out_exc !== 1'b0) begin miscompares++;
      $display("FAIL rst_mid_outs: valid=%b data=%h rd=%0d exc=%b want 0", out_valid, out_data, out_rd, out_exc); end
    do_op(30'h0000_7001, enc(12'h340, 5'd0, F3_CSRRS, 5'd22), 32'h0);
    vectors++; if (o_data !== 32'h0) begin miscompares++; $display("FAIL rst_mid_mscratch: got %h want 0", o_data); end
    $display("reset mid-op: mscratch=%h", o_data);
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_read_cycle();
    test_illegal();
    test_older_wait();
    test_backpressure();
    test_flush();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule

// File: doc/csr_exec.md
Name: csr_exec

Overview:
Execute-stage unit for Zicsr instructions (CSRRW/S/C and the immediate forms), sitting directly upstream of the csr register file.
- Accepts one decoded CSR instruction at a time from issue.
- Waits until all older instructions have retired, then drives the csr read/write port for exactly one cycle.
- Hands the result, or an illegal-instruction exception, to writeback with a valid/ready handshake.
- Serializes CSR ops: at most one instruction in flight.

Parameters:
None. Widths are fixed by RV32.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  issue has a CSR instruction
in_ready  out  1  stage can accept
in_pc  in  30  instruction PC[31:2]
in_insn  in  32  raw instruction word
in_rs1_val  in  32  rs1 register value
older_empty  in  1  no older instruction remains uncommitted
flush  in  1  pipeline kill (csr_setpc from the trap path)
csr_addr  out  12  to csr addr
csr_write  out  2  to csr write: 00 none, 01 set, 10 or, 11 andnot
csr_wdata  out  32  to csr data_in
csr_error  in  1  csr reports an illegal access
csr_rdata  in  32  csr data_out
out_valid  out  1  result available to writeback
out_ready  in  1  writeback accepts
out_pc  out  30  PC of the result
out_rd  out  5  destination register
out_data  out  32  old CSR value; instruction word when out_exc=1
out_exc  out  1  exception flag
out_exc_cause  out  ecause_t  IILLEGAL when out_exc=1, else 0

Behaviour:
- Reset: state=IDLE; out_valid=0, out_exc=0, out_data=0, out_rd=0, out_pc=0; csr_write=00; in_ready=0 during the reset cycle.
- Field decode: rd=insn[11:7]; src=insn[19:15]; addr=insn[31:20]; f3=insn[14:12].
- Operand: immediate forms (f3[2]=1) use a zero-extended 5-bit src; register forms use in_rs1_val.
- Write code:
  - f3[1:0]=01 gives 01.
  - 10 gives 10, or 00 when src==0.
  - 11 gives 11, or 00 when src==0.
- f3 = 000 or 100: illegal.
- Read-only check: addr[11:10]==11 with a nonzero write code is illegal.
- On any illegal access, csr_write is forced to 00.
- States:
  - IDLE: in_ready = !flush. When in_valid & in_ready, latch pc/insn/operand and go to PEND.
  - PEND: csr_* outputs are driven from the latched instruction; csr_write is 00 unless the access fires. The access fires in the cycle older_empty & !flush. In that cycle, csr_write takes the decoded code and the result is captured:
    - out_data = csr_rdata;
    - out_exc = illegal | csr_error;
    - on exception, out_data = insn, out_rd = 0, out_exc_cause = IILLEGAL.
    After firing, go to RESP.
  - RESP: out_valid=1 and all out_* held stable. When out_ready is high, go to IDLE.
- Latency: accepted in cycle N with older_empty=1 gives access in N+1 and out_valid in N+2. One instruction per 3 cycles best case.
- CSR writes are issued in exactly one cycle per instruction, never repeated under backpressure.
- flush (highest priority): from any state, go to IDLE next cycle with out_valid=0, csr_write=00 in that cycle, and in_ready=0 in that cycle. A flush coincident with out_ready still drops the result.
- csr_error is sampled only in the firing cycle. The csr must not commit a write in a cycle where it asserts error.
- Reset mid-operation: state and outputs return to reset values; no partial access is issued.

Decomposition:
- Shared pkg additions:
  - csr_op_t enum (CSR_NONE=00, CSR_SET=01, CSR_OR=10, CSR_ANDN=11), reused by csr.write;
  - F3_CSRRW..F3_CSRRCI constants.
  - ecause_t already lives in the pkg.
- One sub-module, csr_exec_decode: combinational insn + rs1 to addr, op, wdata, illegal. The FSM stays in csr_exec.

Test Plan:
1. mscratch=0; CSRRW x5,0x340,x6 with rs1_val=0x12345678, older_empty=1 -> firing cycle csr_write=01, csr_wdata=0x12345678; out_valid on N+2 with out_rd=5, out_data=0, out_exc=0; a later read of 0x340 returns 0x12345678.
2. CSRRS x7,0xC00,x0 -> csr_write=00 throughout; out_data equals cycle[31:0] sampled in the firing cycle; out_exc=0.
3. CSRRWI x1,0xC02,5 -> csr_write=00, out_exc=1, out_exc_cause=IILLEGAL, out_data=insn, out_rd=0.
4. Hold older_empty=0 for 4 cycles after accept -> state stays PEND, csr_write=00, in_ready=0; access fires in the cycle older_empty rises.
5. out_ready=0 for 3 cycles in RESP -> out_* stable, exactly one csr_write pulse, in_ready=0; release -> IDLE, new instruction accepted.
6. flush asserted in PEND (older_empty=1) -> csr_write=00 that cycle; next cycle IDLE, out_valid=0; mscratch unchanged.
